// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit sitting behind the memory-access step of the
// multicycle RISC-V core. It accepts one load or store at a time and drives
// a req/ack handshake to a variable-latency data memory. It then returns a
// single-cycle completion pulse carrying the formatted load data or an error.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req, ready          core request / LSU idle (request accepted when both 1)
//   we, funct3, addr,   operation descriptor, sampled at accept
//   wdata
//   done, rdata, err    completion pulse, load result, error flag
//   mem_req, mem_we,    memory request and its word address, strobes and
//   mem_addr,           lane-replicated store data; held stable while
//   mem_wstrb,          mem_req is high
//   mem_wdata
//   mem_ack, mem_rdata  memory completion and read word
module riscv_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  addr_lo_reg;
    logic [31:0] count_reg;

    logic        legal_f3;
    logic        misaligned;
    logic        bad_req;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;
    logic        timeout_hit;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_fmt;

    assign ready = (state_reg == IDLE);
    assign done  = (state_reg == RESP);

    // Decode of the request currently presented on the core interface.
    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        strb_next  = 4'b0000;
        wdata_next = 32'h0;
        if (we)
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        // funct3[1:0] gives the access size for every legal encoding.
        if (funct3[1:0] == 2'b01 && addr[0])
            misaligned = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            misaligned = 1'b1;
        case (funct3[1:0])
            2'b00: begin
                strb_next  = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                strb_next  = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                strb_next  = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    assign bad_req = !legal_f3 || misaligned;

    // The counter reaches TIMEOUT-1 on the TIMEOUT-th cycle without ack.
    assign timeout_hit = (TIMEOUT != 0) && (count_reg == TIMEOUT - 1);

    // Load formatting uses the lane offset and funct3 latched at accept.
    always_comb begin
        lane_byte = mem_rdata[{addr_lo_reg, 3'b000} +: 8];
        lane_half = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
            3'b010:  load_fmt = mem_rdata;
            3'b100:  load_fmt = {24'h0, lane_byte};
            3'b101:  load_fmt = {16'h0, lane_half};
            default: load_fmt = 32'h0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = bad_req ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            we_reg      <= 1'b0;
            funct3_reg  <= 3'b000;
            addr_lo_reg <= 2'b00;
            count_reg   <= 32'h0;
            rdata       <= 32'h0;
            err         <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wstrb   <= 4'b0000;
            mem_wdata   <= 32'h0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (req) begin
                    we_reg      <= we;
                    funct3_reg  <= funct3;
                    addr_lo_reg <= addr[1:0];
                    count_reg   <= 32'h0;
                    if (bad_req) begin
                        err   <= 1'b1;
                        rdata <= 32'h0;
                    end else begin
                        err       <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= we;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wstrb <= we ? strb_next : 4'b0000;
                        mem_wdata <= we ? wdata_next : 32'h0;
                    end
                end
                ACCESS: begin
                    // An ack arriving on the timeout cycle still wins.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        err     <= 1'b0;
                        rdata   <= we_reg ? 32'h0 : load_fmt;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        rdata   <= 32'h0;
                    end else begin
                        count_reg <= count_reg + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed testbench for riscv_lsu, built with TIMEOUT=4. Each transaction
// is driven at one clock edge plus 1 time unit, and outputs are sampled at
// that same point. The memory side acks after a per-transaction number of
// wait cycles, or never when the count is negative.
module tb_riscv_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        ready;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    riscv_lsu #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .req(req), .ready(ready), .we(we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .done(done),
        .rdata(rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one transaction starting in IDLE; returns at edge+1 back in IDLE.
    task automatic do_op(input string tag, input logic op_we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd_word, input int waits, input bit busy,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_lat, input int exp_req_cyc,
                         input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata);
        int cyc;
        int req_cyc;
        bit seen;
        cyc = 0;
        req_cyc = 0;
        seen = 1'b0;
        check({tag, ":ready_idle"}, {31'h0, ready}, 32'h1);
        req = 1'b1; we = op_we; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd_word;
        tick();
        req = 1'b0;
        cyc = 1;
        while (cyc < 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (mem_req) begin
                    req_cyc++;
                    check({tag, ":mem_addr"}, mem_addr, exp_maddr);
                    check({tag, ":mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, exp_strb});
                    check({tag, ":mem_we"}, {31'h0, mem_we}, {31'h0, op_we});
                    if (op_we)
                        check({tag, ":mem_wdata"}, mem_wdata, exp_wdata);
                    mem_ack = (waits >= 0) && (req_cyc == waits + 1);
                end else begin
                    mem_ack = 1'b0;
                end
                if (busy) begin
                    check({tag, ":ready_busy"}, {31'h0, ready}, 32'h0);
                    req = 1'b1; addr = 32'hDEAD_0000; we = ~op_we;
                end
                tick();
                cyc++;
            end
        end
        mem_ack = 1'b0;
        req = 1'b0;
        if (!seen) begin
            check({tag, ":done_seen"}, 32'h0, 32'h1);
        end else begin
            check({tag, ":latency"}, cyc, exp_lat);
            check({tag, ":err"}, {31'h0, err}, {31'h0, exp_err});
            check({tag, ":rdata"}, rdata, exp_rdata);
        end
        check({tag, ":mem_req_cycles"}, req_cyc, exp_req_cyc);
        $display("op %s we=%0d f3=%0d addr=0x%08h -> lat=%0d err=%0d rdata=0x%08h",
                 tag, op_we, f3, a, cyc, err, rdata);
        tick();
        check({tag, ":done_pulse"}, {31'h0, done}, 32'h0);
        check({tag, ":ready_after"}, {31'h0, ready}, 32'h1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst:ready", {31'h0, ready}, 32'h1);
        check("rst:done", {31'h0, done}, 32'h0);
        check("rst:err", {31'h0, err}, 32'h0);
        check("rst:rdata", rdata, 32'h0);
        check("rst:mem_req", {31'h0, mem_req}, 32'h0);
        check("rst:mem_addr", mem_addr, 32'h0);
        check("rst:mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst:mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        tick();

        //     tag     we    f3      addr          wdata         mem_rdata     waits busy err   rdata         lat req maddr         strb     mem_wdata
        do_op("lb",    1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_7F01, 0,  1'b0, 1'b0, 32'hFFFF_FF80, 2, 1, 32'h0000_0100, 4'b0000, 32'h0);
        do_op("lbu",   1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_7F01, 0,  1'b0, 1'b0, 32'h0000_0080, 2, 1, 32'h0000_0100, 4'b0000, 32'h0);
        do_op("sh",    1'b1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'hFFFF_FFFF, 3,  1'b0, 1'b0, 32'h0,         5, 4, 32'h0000_0204, 4'b1100, 32'hABCD_ABCD);
        do_op("lw_mis",1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h1111_1111, 0,  1'b0, 1'b1, 32'h0,         1, 0, 32'h0,         4'b0000, 32'h0);
        do_op("ld_011",1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h1111_1111, 0,  1'b0, 1'b1, 32'h0,         1, 0, 32'h0,         4'b0000, 32'h0);
        do_op("lw_to", 1'b0, 3'b010, 32'h0000_0040, 32'h0,         32'h2222_2222, -1, 1'b0, 1'b1, 32'h0,         5, 4, 32'h0000_0040, 4'b0000, 32'h0);

        // Late ack while idle must not produce a completion
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack:done", {31'h0, done}, 32'h0);
            check("late_ack:mem_req", {31'h0, mem_req}, 32'h0);
            tick();
        end

        do_op("lh_busy",1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 2,  1'b1, 1'b0, 32'hFFFF_80FF, 4, 3, 32'h0000_0100, 4'b0000, 32'h0);
        do_op("lhu",   1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h80FF_7F01, 0,  1'b0, 1'b0, 32'h0000_7F01, 2, 1, 32'h0000_0100, 4'b0000, 32'h0);
        do_op("sb",    1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,         1,  1'b0, 1'b0, 32'h0,         3, 2, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5);
        do_op("sw",    1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_BABE, 32'h0,         0,  1'b0, 1'b0, 32'h0,         2, 1, 32'h0000_0010, 4'b1111, 32'hCAFE_BABE);

        // Reset during ACCESS of a store
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0000_0010; wdata = 32'h5555_5555;
        tick();
        req = 1'b0;
        check("rst_mid:mem_req_before", {31'h0, mem_req}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid:mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mid:ready", {31'h0, ready}, 32'h1);
        check("rst_mid:done", {31'h0, done}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid:no_done", {31'h0, done}, 32'h0);
            tick();
        end
        $display("op reset_mid_access done");

        do_op("lw_post",1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h1357_2468, 0,  1'b0, 1'b0, 32'h1357_2468, 2, 1, 32'h0000_0010, 4'b0000, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
